// File: rtl/mul_div_seq_if.sv
// mul_div_seq_if: request and SFR write-back bus of the MUL AB / DIV AB sequencer.
// The decoder side (master) drives the request and operands; the sequencer
// (slave) drives busy/done, the SFR byte-write bus and the PSW flag update.
interface mul_div_seq_if;
    logic       start;
    logic       op;
    logic [7:0] acc_in;
    logic [7:0] b_in;
    logic       busy;
    logic       done;
    logic       wr_en;
    logic       wr_bit_en;
    logic [7:0] addr;
    logic [7:0] data_out;
    logic       flag_wr;
    logic       ov_out;
    logic       cy_out;

    modport master (
        output start, op, acc_in, b_in,
        input  busy, done, wr_en, wr_bit_en, addr, data_out, flag_wr, ov_out, cy_out
    );

    modport slave (
        input  start, op, acc_in, b_in,
        output busy, done, wr_en, wr_bit_en, addr, data_out, flag_wr, ov_out, cy_out
    );
endinterface

// File: rtl/mul_div_seq.sv
// mul_div_seq: multi-cycle sequencer for the 8051 MUL AB / DIV AB instructions.
// Operands are captured on the start edge, the result is built by shift-add
// (MUL) or restoring division (DIV), then written back as ACC first, B second,
// together with the PSW OV/CY update. A divide by zero skips the write-back
// and only raises OV.
// Optional macro MULDIV_FAST_EN: computes the whole result in a single CALC
// cycle instead of eight iterations; sequencing and flags are unchanged.
module mul_div_seq #(
    parameter logic [7:0] ADDR_ACC = 8'hE0,
    parameter logic [7:0] ADDR_B   = 8'hF0
) (
    input logic          clock,
    input logic          reset,
    mul_div_seq_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        WR_A,
        WR_B,
        DZ
    } state_t;

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic        r_op;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [15:0] r_prod;
    logic [7:0]  r_quo;
    logic [7:0]  r_rem;

    logic        r_busy;
    logic        r_done;
    logic        r_wrEn;
    logic [7:0]  r_addr;
    logic [7:0]  r_dataOut;
    logic        r_flagWr;
    logic        r_ov;

    logic        w_accept;
    logic        w_lastIter;
    logic [15:0] w_prodNext;
    logic [7:0]  w_quoNext;
    logic [7:0]  w_remNext;

    // A new request is taken from IDLE, and also from the final cycle of an
    // operation (WR_B or DZ) so back-to-back instructions lose no cycle.
    assign w_accept = bus.start && ((r_state == IDLE) || (r_state == WR_B) || (r_state == DZ));

`ifdef MULDIV_FAST_EN
    // Whole product and quotient/remainder straight from the latched operands;
    // the divisor is never zero here because that case goes to DZ instead.
    always_comb begin
        w_prodNext = {8'h00, r_a} * {8'h00, r_b};
        w_quoNext  = 8'h00;
        w_remNext  = 8'h00;
        if (r_b != 8'h00) begin
            w_quoNext = r_a / r_b;
            w_remNext = r_a % r_b;
        end
        w_lastIter = 1'b1;
    end
`else
    logic [8:0]  w_shift;
    logic [15:0] w_partial;

    // One step per cycle: MUL adds the shifted multiplicand when multiplier
    // bit r_cnt is set; DIV shifts in the next dividend bit (MSB first) and
    // subtracts the divisor when it fits. The shifted remainder needs 9 bits
    // because it can exceed 255 before the subtraction.
    always_comb begin
        w_partial = 16'h0000;
        if (r_b[r_cnt]) begin
            w_partial = {8'h00, r_a} << r_cnt;
        end
        w_prodNext = r_prod + w_partial;
        w_shift    = {r_rem, r_a[3'd7 - r_cnt]};
        w_quoNext  = {r_quo[6:0], 1'b0};
        w_remNext  = w_shift[7:0];
        if (w_shift >= {1'b0, r_b}) begin
            w_quoNext = {r_quo[6:0], 1'b1};
            w_remNext = 8'(w_shift - {1'b0, r_b});
        end
        w_lastIter = (r_cnt == 3'd7);
    end
`endif

    // Sequencer state, datapath registers and registered outputs; each output
    // register is loaded on the edge that enters the state it belongs to.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= 3'd0;
            r_op      <= 1'b0;
            r_a       <= 8'h00;
            r_b       <= 8'h00;
            r_prod    <= 16'h0000;
            r_quo     <= 8'h00;
            r_rem     <= 8'h00;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_wrEn    <= 1'b0;
            r_addr    <= 8'h00;
            r_dataOut <= 8'h00;
            r_flagWr  <= 1'b0;
            r_ov      <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_wrEn    <= 1'b0;
            r_addr    <= 8'h00;
            r_dataOut <= 8'h00;
            r_flagWr  <= 1'b0;
            r_ov      <= 1'b0;
            if (w_accept) begin
                r_a    <= bus.acc_in;
                r_b    <= bus.b_in;
                r_op   <= bus.op;
                r_cnt  <= 3'd0;
                r_prod <= 16'h0000;
                r_quo  <= 8'h00;
                r_rem  <= 8'h00;
                r_busy <= 1'b1;
                if (bus.op && (bus.b_in == 8'h00)) begin
                    r_state  <= DZ;
                    r_flagWr <= 1'b1;
                    r_ov     <= 1'b1;
                    r_done   <= 1'b1;
                end else begin
                    r_state <= CALC;
                end
            end else begin
                case (r_state)
                    CALC: begin
                        r_prod <= w_prodNext;
                        r_quo  <= w_quoNext;
                        r_rem  <= w_remNext;
                        r_cnt  <= r_cnt + 3'd1;
                        if (w_lastIter) begin
                            r_state   <= WR_A;
                            r_wrEn    <= 1'b1;
                            r_addr    <= ADDR_ACC;
                            r_dataOut <= r_op ? w_quoNext : w_prodNext[7:0];
                        end
                    end
                    WR_A: begin
                        r_state   <= WR_B;
                        r_wrEn    <= 1'b1;
                        r_addr    <= ADDR_B;
                        r_dataOut <= r_op ? r_rem : r_prod[15:8];
                        r_flagWr  <= 1'b1;
                        r_ov      <= !r_op && (r_prod[15:8] != 8'h00);
                        r_done    <= 1'b1;
                    end
                    WR_B, DZ: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.wr_en     = r_wrEn;
    assign bus.wr_bit_en = 1'b0;
    assign bus.addr      = r_addr;
    assign bus.data_out  = r_dataOut;
    assign bus.flag_wr   = r_flagWr;
    assign bus.ov_out    = r_ov;
    assign bus.cy_out    = 1'b0;

endmodule

// File: doc/mul_div_seq.md
Name: mul_div_seq

Overview:
- Multi-cycle sequencer for the 8051 MUL AB / DIV AB instructions.
- Captures ACC and B operands and computes iteratively: shift-add for MUL, restoring division for DIV.
- Writes results back over the shared SFR write bus: ACC first, then B.
- Issues the PSW OV/CY flag update. Sits between instruction decode and the ACC/B/PSW SFR blocks.

Parameters:
- ADDR_ACC, 8'hE0, SFR direct address of ACC.
- ADDR_B, 8'hF0, SFR direct address of B.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op  input  1  0 = MUL AB, 1 = DIV AB.
- acc_in  input  8  current ACC value.
- b_in  input  8  current B value.
- busy  output  1  high in every non-IDLE state.
- done  output  1  one-cycle completion pulse.
- wr_en  output  1  SFR byte-write strobe.
- wr_bit_en  output  1  always 0 (byte writes only).
- addr  output  8  SFR write address.
- data_out  output  8  SFR write data.
- flag_wr  output  1  PSW flag update strobe.
- ov_out  output  1  OV value; valid while flag_wr = 1.
- cy_out  output  1  CY value; always 0.

Behaviour:
- Interface: one clock named clock. Reset named reset, asynchronous and active-high.
- Reset: state IDLE, iteration counter 0, operand/result registers 0.
- During reset all outputs are 0 (busy, done, wr_en, wr_bit_en, addr, data_out, flag_wr, ov_out, cy_out).
- Outputs are decoded from the registered state only; no combinational path from start/op/acc_in/b_in.
- States: IDLE, CALC, WR_A, WR_B, DZ.
- Edge E0, start=1 in IDLE: latch acc_in, b_in, op. Transition:
  - op=1 and b_in=0: go to DZ.
  - otherwise: go to CALC, counter = 0.
- CALC: one iteration per cycle, 8 cycles (edges E1..E8). Counter 0..7; at counter 7 go to WR_A.
  - MUL: 16-bit accumulator; add multiplicand << i when multiplier bit i = 1.
  - DIV: restoring; 8-bit partial remainder; shift in dividend MSB first; subtract divisor when remainder >= divisor; set quotient bit.
- Results:
  - MUL: A = product[7:0], B = product[15:8], OV = (product > 255), CY = 0.
  - DIV: A = quotient, B = remainder, OV = 0, CY = 0.
- WR_A (cycle after E8): wr_en=1, addr=ADDR_ACC, data_out=A result. Next state WR_B.
- WR_B (cycle after E9):
  - wr_en=1, addr=ADDR_B, data_out=B result.
  - flag_wr=1, ov_out=OV, cy_out=0, done=1.
  - Next state IDLE.
- Latency: done is visible in the 10th cycle after the start edge; next start is accepted at E10.
- DZ (divide by zero), one cycle: no ACC/B write (wr_en=0); flag_wr=1, ov_out=1, cy_out=0, done=1. Next state IDLE.
- Start while busy is ignored and not queued. acc_in/b_in changes after E0 have no effect.
- Reset mid-operation: immediate return to IDLE; a write or flag strobe in progress is dropped. No partial results are written after reset release.
- Outside WR_A/WR_B/DZ: wr_en=0, flag_wr=0, addr=0, data_out=0, ov_out=0.

Optional Feature:
- Macro: MULDIV_FAST_EN.
- Defined: CALC lasts one cycle; the full product or quotient/remainder is computed combinationally from the latched operands. done appears in the 3rd cycle after the start edge. All write ordering, flags and DZ behaviour are unchanged.
- Undefined: 8-cycle iterative CALC as specified above.

Test Plan:
- MUL, acc_in=8'h50, b_in=8'hA0, pulse start -> WR_A writes E0<-00, then WR_B writes F0<-32. ov_out=1, cy_out=0, done in cycle 10, busy for 10 cycles.
- MUL, acc_in=8'h0C, b_in=8'h0A -> ACC<-78, B<-00, ov_out=0. Also 8'hFF*8'hFF -> ACC<-01, B<-FE, ov_out=1.
- DIV, acc_in=8'hFB, b_in=8'h12 -> ACC<-0D, B<-11, ov_out=0. Also 8'h05/8'h07 -> ACC<-00, B<-05.
- DIV, b_in=0 -> single DZ cycle at cycle 1 after start: flag_wr=1, ov_out=1, done=1, wr_en never asserted.
- Start re-asserted at cycle 3 of a MUL with different operands -> ignored; original results written. A start at E10 is accepted.
- Reset asserted at cycle 5 of CALC -> all outputs 0 immediately, no writes after release, next start completes normally. Repeat with MULDIV_FAST_EN defined -> done in cycle 3 with identical results.
